// File: rtl/rom_fetch_pkg.sv
// ----------------------------------------------------------------------------
// rom_fetch_pkg
//
// Shared types for the ROM fetch stage:
//   state_t     fetch sequencer states (IDLE, RUN, HALT)
//   entry_t     one buffered fetch result {data, addr, error} at the
//               default ROM geometry
//   ADDR_WIDTH  default ROM address width
//   DATA_WIDTH  default ROM word width
//   ENTRY_WIDTH packed width of entry_t
// ----------------------------------------------------------------------------
package rom_fetch_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Field order matches the flat vector the fetch stage writes into its
    // buffer: data in the top bits, then address, then the error flag.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  error;
    } entry_t;

    localparam int ENTRY_WIDTH = $bits(entry_t);

endpackage

// File: rtl/rom_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//
// Two-entry synchronous FIFO used to hold fetched ROM words until the
// consumer accepts them. The head entry is presented combinationally so a
// word is visible the cycle after it is pushed.
//
// Ports:
//   clk         clock, rising edge
//   srst        synchronous active-high reset (empties FIFO, zeroes storage)
//   push        write push_data at the tail (ignored when full without pop)
//   push_data   entry to write
//   pop         remove head entry (ignored when empty)
//   flush       discard all entries; dominates push and pop
//   count       number of stored entries (0..2)
//   head_data   oldest entry
//   head_valid  count != 0
// ----------------------------------------------------------------------------
module fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter int width = ENTRY_WIDTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic [width-1:0] head_data,
    output logic             head_valid
);

    logic [width-1:0] mem_reg [2];
    logic             rd_ptr_reg;
    logic             rd_ptr_next;
    logic             wr_ptr_reg;
    logic             wr_ptr_next;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same
    // cycle; the write then lands in the slot being vacated, which keeps the
    // order intact because wr_ptr == rd_ptr whenever the FIFO is full.
    assign do_pop  = pop  && (count_reg != 2'd0) && !flush;
    assign do_push = push && ((count_reg != 2'd2) || do_pop) && !flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
            count_next  = 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the
    // first word arrives.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign count      = count_reg;
    assign head_data  = mem_reg[rd_ptr_reg];
    assign head_valid = (count_reg != 2'd0);

endmodule

// File: rtl/rom_fetch.sv
// ----------------------------------------------------------------------------
// rom_fetch
//
// Sequential fetch stage in front of a combinational ROM. A program counter
// drives the ROM address; each returned word is captured together with its
// address and error flag into a 2-entry buffer and handed to the decode
// stage over a valid/ready handshake. Back-pressure stalls the counter once
// the buffer is full, so no word is lost or fetched twice.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          start fetching at start_addr_i (IDLE/HALT only)
//   start_addr_i     first fetch address
//   redirect_i       flush buffer and restart at redirect_addr_i (any state)
//   redirect_addr_i  redirect target
//   rom_addr_o       ROM address (the program counter)
//   rom_data_i       ROM word for rom_addr_o, same cycle
//   rom_error_i      ROM error flag for rom_addr_o, same cycle
//   instr_o          head word
//   instr_addr_o     address of head word
//   instr_error_o    ROM error flag captured with head word
//   instr_valid_o    head entry present
//   instr_ready_i    consumer takes the head this cycle
//   busy_o           sequencer in RUN
//   halted_o         sequencer in HALT
// ----------------------------------------------------------------------------
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH,
    parameter int data_width = DATA_WIDTH,
    parameter bit wrap_en    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [addr_width-1:0] start_addr_i,
    input  logic                  redirect_i,
    input  logic [addr_width-1:0] redirect_addr_i,
    output logic [addr_width-1:0] rom_addr_o,
    input  logic [data_width-1:0] rom_data_i,
    input  logic                  rom_error_i,
    output logic [data_width-1:0] instr_o,
    output logic [addr_width-1:0] instr_addr_o,
    output logic                  instr_error_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic                  busy_o,
    output logic                  halted_o
);

    localparam int entry_width = data_width + addr_width + 1;
    localparam logic [addr_width-1:0] pc_one  = addr_width'(1);
    localparam logic [addr_width-1:0] pc_last = {addr_width{1'b1}};

    state_t                  state_reg;
    state_t                  state_next;
    logic [addr_width-1:0]   pc_reg;
    logic [addr_width-1:0]   pc_next;

    logic                    push;
    logic                    pop;
    logic                    flush;
    logic [1:0]              fifo_count;
    logic                    fifo_room;
    logic [entry_width-1:0]  push_entry;
    logic [entry_width-1:0]  head_entry;
    logic                    head_valid;

    // ------------------------------------------------------------------
    // Entry buffer
    // ------------------------------------------------------------------
    assign push_entry = {rom_data_i, pc_reg, rom_error_i};

    fetch_fifo #(
        .width (entry_width)
    ) u_fifo (
        .clk        (clk_i),
        .srst       (rst_i),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (flush),
        .count      (fifo_count),
        .head_data  (head_entry),
        .head_valid (head_valid)
    );

    assign fifo_room = (fifo_count != 2'd2);

    // A pop in a redirect cycle is still a completed handshake: the flush
    // removes the remaining entries and the consumed word is not replayed.
    assign pop = head_valid && instr_ready_i;

    // ------------------------------------------------------------------
    // Sequencer: next state, next pc, buffer controls
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = 1'b0;
        flush      = 1'b0;

        if (redirect_i) begin
            // Redirect beats start and suppresses this cycle's push: the word
            // on the ROM belongs to the abandoned stream.
            flush      = 1'b1;
            pc_next    = redirect_addr_i;
            state_next = RUN;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    // Restarting from HALT keeps any undelivered entries.
                    if (start_i) begin
                        pc_next    = start_addr_i;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    // A pop frees a slot in the same cycle, so a full buffer
                    // still accepts a new word while the consumer is taking.
                    push = fifo_room || pop;
                    if (push) begin
                        pc_next = pc_reg + pc_one;
                        if (rom_error_i || (!wrap_en && (pc_reg == pc_last))) begin
                            state_next = HALT;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr_o    = pc_reg;
    assign instr_o       = head_entry[entry_width-1 -: data_width];
    assign instr_addr_o  = head_entry[addr_width:1];
    assign instr_error_o = head_entry[0];
    assign instr_valid_o = head_valid;
    assign busy_o        = (state_reg == RUN);
    assign halted_o      = (state_reg == HALT);

endmodule
